// File: rtl/smm_operand_loader_if.sv
// Element stream in, packed operand buses and load/result strobes out, for the Strassen operand loader.
// slave = loader side, master = element source / multiplier side.
interface smm_operand_loader_if #(
  parameter int DATAWIDTH = 32,
  parameter int BUSWIDTH  = 128
);
  logic signed [DATAWIDTH-1:0] in_data;
  logic                        in_valid;
  logic                        in_sel;
  logic                        in_ready;
  logic [BUSWIDTH-1:0]         A;
  logic [BUSWIDTH-1:0]         B;
  logic                        load;
  logic                        sel;
  logic                        res_valid;
  logic                        busy;

  modport master (
    output in_data, in_valid, in_sel,
    input  in_ready, A, B, load, sel, res_valid, busy
  );

  modport slave (
    input  in_data, in_valid, in_sel,
    output in_ready, A, B, load, sel, res_valid, busy
  );
endinterface

// File: rtl/smm_operand_loader.sv
// Packs 4 A + 4 B elements, strobes load, pulses res_valid RES_LAT cycles later; input is blocked until then.
// SMM_LOADER_FLUSH_EN adds a flush port that abandons a partial fill.
module smm_operand_loader #(
  parameter int DATAWIDTH = 32,
  parameter int BLOCKSIZE = DATAWIDTH*1,
  parameter int BUSWIDTH  = BLOCKSIZE*4,
  parameter int RES_LAT   = 2
) (
  input logic                 clk,
  input logic                 rst,
  smm_operand_loader_if.slave io
`ifdef SMM_LOADER_FLUSH_EN
  ,
  input logic                 flush
`endif
);
  localparam int WW = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

  typedef enum logic [1:0] {FILL_A, FILL_B, ISSUE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [WW-1:0]       wcnt_q, wcnt_d;
  logic [BUSWIDTH-1:0] a_q, b_q;
  logic                sel_q;
  logic                ready, xfer, wr_a, wr_b, load, res_valid, flush_req;

`ifdef SMM_LOADER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    load      = 1'b0;
    res_valid = 1'b0;
    ready     = ((state_q == FILL_A) || (state_q == FILL_B)) && !rst;
    xfer      = io.in_valid && ready;
    case (state_q)
      FILL_A: begin
        // flush wins over a same-cycle transfer; that element is dropped
        if (flush_req) begin
          cnt_d = 2'd0;
        end else if (xfer) begin
          wr_a  = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = FILL_B;
        end
      end
      FILL_B: begin
        if (flush_req) begin
          cnt_d   = 2'd0;
          state_d = FILL_A;
        end else if (xfer) begin
          wr_b  = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ISSUE;
        end
      end
      ISSUE: begin
        load    = 1'b1;
        wcnt_d  = WW'(RES_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          res_valid = 1'b1;
          state_d   = FILL_A;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      default: state_d = FILL_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL_A;
      cnt_q   <= 2'd0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Element k of each half lands in slot k; sel is captured with a0 only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wr_a && (cnt_q == 2'(k))) a_q[k*DATAWIDTH +: DATAWIDTH] <= io.in_data;
        if (wr_b && (cnt_q == 2'(k))) b_q[k*DATAWIDTH +: DATAWIDTH] <= io.in_data;
      end
      if (wr_a && (cnt_q == 2'd0)) sel_q <= io.in_sel;
    end
  end

  assign io.in_ready  = ready;
  assign io.A         = a_q;
  assign io.B         = b_q;
  assign io.sel       = sel_q;
  assign io.load      = load;
  assign io.res_valid = res_valid;
  assign io.busy      = !((state_q == FILL_A) && (cnt_q == 2'd0));
endmodule
